// File: rtl/window_streamer_pkg.sv
// Shared constants, pixel/window types and control states for the window streamer.
package harris_pkg;

  localparam int unsigned WIN     = 6;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COUNT_W = 64;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [0:WIN-1] col_t;
  typedef pix_t [0:WIN-1][0:WIN-1] win_t;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StLast
  } state_e;

endpackage

// File: rtl/window_streamer_if.sv
// Pixel-in / window-out handshake bundle of the window streamer.
interface window_streamer_if;
  import harris_pkg::*;

  logic                 pix_valid;
  logic                 pix_ready;
  pix_t                 pix_data;
  win_t                 window;
  logic                 win_valid;
  logic                 win_ready;
  logic [COUNT_W-1:0]   count;
  logic                 frame_done;

  // Pixel source / window sink side.
  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, window, win_valid, count, frame_done
  );

  // Streamer side.
  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, window, win_valid, count, frame_done
  );

endinterface

// File: rtl/window_streamer_line_buffer.sv
// One-line delay: circular RAM whose single pointer reads the old entry and writes the new one.
module line_buffer
  import harris_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t            mem [DEPTH];
  logic [PtrW-1:0] ptr_q;

  // Read-before-write: dout is the pixel stored one line ago at this column.
  assign dout = mem[ptr_q];

  // Pointer advances with each shift and wraps at the line length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Storage is left uninitialised; frame gating keeps stale contents out of windows.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/window_streamer.sv
// Raster pixel stream in, every fully populated 6x6 window out with its index in the frame.
module window_streamer
  import harris_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic              clk,
  input  logic              reset,
  window_streamer_if.slave  bus
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  state_e             state_q, state_d;
  win_t               sr_q, sr_d;
  win_t               window_q, window_d;
  logic               win_valid_q, win_valid_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               frame_done_q, frame_done_d;

  logic pix_ready, pix_acc, win_acc, col_last, row_last, completes;
  pix_t lb_in  [WIN-1];
  pix_t lb_out [WIN-1];
  col_t new_col;

  assign pix_ready = (state_q != StLast) && (!win_valid_q || bus.win_ready);
  assign pix_acc   = bus.pix_valid && pix_ready;
  assign win_acc   = win_valid_q && bus.win_ready;
  assign col_last  = (col_q == ColW'(IMG_W - 1));
  assign row_last  = (row_q == RowW'(IMG_H - 1));
  assign completes = pix_acc && (row_q >= RowW'(WIN - 1)) && (col_q >= ColW'(WIN - 1));

  // Five chained line buffers: lb_out[k] is the pixel k+1 lines above the incoming one.
  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = bus.pix_data;
    end else begin : g_link
      assign lb_in[k] = lb_out[k-1];
    end
    line_buffer #(
      .DEPTH (IMG_W)
    ) u_lb (
      .clk   (clk),
      .reset (reset),
      .en    (pix_acc),
      .din   (lb_in[k]),
      .dout  (lb_out[k])
    );
  end

  // Newest column, oldest line at the top.
  always_comb begin
    new_col = '0;
    for (int i = 0; i < WIN - 1; i++) begin
      new_col[i] = lb_out[WIN-2-i];
    end
    new_col[WIN-1] = bus.pix_data;
  end

  // Shift register: drop the oldest column, append the newest.
  always_comb begin
    sr_d = sr_q;
    if (pix_acc) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++) begin
          sr_d[i][j] = sr_q[i][j+1];
        end
        sr_d[i][WIN-1] = new_col[i];
      end
    end
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_acc) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
    end
  end

  // Control FSM plus output register and window counter.
  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    win_valid_d  = win_valid_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    if (win_acc) begin
      win_valid_d = 1'b0;
      count_d     = count_q + 1'b1;
    end
    if (completes) begin
      window_d    = sr_d;
      win_valid_d = 1'b1;
    end
    unique case (state_q)
      StFill: if (pix_acc && row_q == RowW'(WIN - 2) && col_last) state_d = StRun;
      StRun:  if (pix_acc && row_last && col_last) state_d = StLast;
      StLast: begin
        if (win_acc) begin
          state_d      = StFill;
          frame_done_d = 1'b1;
          count_d      = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      col_q        <= '0;
      row_q        <= '0;
      sr_q         <= '0;
      window_q     <= '0;
      win_valid_q  <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      sr_q         <= sr_d;
      window_q     <= window_d;
      win_valid_q  <= win_valid_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.window     = window_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.count      = count_q;
  assign bus.frame_done = frame_done_q;

endmodule
